reg_file_param: RTL
===================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 16: register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; register count DEPTH = 2**ADDR_W.
REQ-003 Parameter ACC_ADDR, default 1: index of the accumulator register mirrored on acc_data.
REQ-004 Parameter ISZ_ADDR, default 3: index of the iszero register, writable only via the iszero port.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset, sampled on the clock rising edge.
REQ-007 ra_a  in  ADDR_W  read address, port A.
REQ-008 ra_b  in  ADDR_W  read address, port B.
REQ-009 rd_en  in  1  read enable for both read ports.
REQ-010 wa  in  ADDR_W  general write address.
REQ-011 write_data  in  DATA_W  general write data.
REQ-012 reg_write  in  1  general write enable.
REQ-013 iszero_data  in  DATA_W  iszero-port write data.
REQ-014 iszero_write  in  1  iszero-port write enable, targets ISZ_ADDR only.
REQ-015 read_data_a  out  DATA_W  registered read result, port A.
REQ-016 read_data_b  out  DATA_W  registered read result, port B.
REQ-017 acc_data  out  DATA_W  current contents of register ACC_ADDR.
REQ-018 iszero_flag  out  1  high when register ISZ_ADDR equals zero.

Function
REQ-019 The block SHALL hold DEPTH registers of DATA_W bits.
REQ-020 Register 0 SHALL always read as zero; writes to address 0 SHALL be discarded.
REQ-021 reg_write=1 with wa not 0 and not ISZ_ADDR SHALL load write_data into register wa at the rising edge.
REQ-022 reg_write=1 with wa=ISZ_ADDR SHALL be discarded; register ISZ_ADDR changes only through iszero_write.
REQ-023 iszero_write=1 SHALL load iszero_data into register ISZ_ADDR at the rising edge, independent of reg_write.
REQ-024 Reads SHALL be synchronous: with rd_en=1, read_data_a/b SHALL show register ra_a/ra_b one cycle after the sampling edge.
REQ-025 With rd_en=0, read_data_a/b SHALL hold their previous values.
REQ-026 A read and an accepted write to the same address at the same edge SHALL return the newly written data (write-first bypass), on both ports independently.
REQ-027 Bypass SHALL apply to iszero_write when ra_x=ISZ_ADDR; discarded writes (REQ-020, REQ-022) SHALL NOT bypass.
REQ-028 acc_data SHALL reflect register ACC_ADDR combinationally from state, updating the cycle after a write to ACC_ADDR.
REQ-029 iszero_flag SHALL be combinational from register ISZ_ADDR.
REQ-030 Illegal parameters (ACC_ADDR or ISZ_ADDR of 0, ACC_ADDR=ISZ_ADDR, or either out of range) SHALL halt elaboration with an error.

Reset
REQ-031 reset=1 at a rising edge SHALL clear every register, read_data_a and read_data_b to 0; iszero_flag then reads 1.
REQ-032 reset SHALL take priority over any simultaneous write or read; inputs during reset SHALL have no effect.
REQ-033 Reset asserted mid-sequence SHALL discard any write presented at the same edge.

Verification
REQ-034 Defaults; for each wa=0..15: reg_write, write_data=16'hABCD, then read via port A -> 16'hABCD for all except addresses 0 and 3 -> 0.
REQ-035 iszero_write, iszero_data=16'hFFFF -> register 3 reads 16'hFFFF, iszero_flag=0; then iszero_data=0 -> iszero_flag=1.
REQ-036 Same edge: reg_write wa=5, data 16'h1234, rd_en, ra_a=5, ra_b=5 -> both ports read 16'h1234 the next cycle.
REQ-037 Write 16'h00FF to address 1 -> acc_data=16'h00FF the next cycle; rd_en=0 while changing ra_a -> read_data_a unchanged.
REQ-038 Fill registers, assert reset together with reg_write wa=2 -> all reads 0, acc_data=0, iszero_flag=1.
REQ-039 DATA_W=8, ADDR_W=3: write 8'hA5 to address 7 -> read 8'hA5; ACC_ADDR=ISZ_ADDR -> elaboration error.

Source files
------------

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//
// Parameterised register file with two registered read ports, one general
// write port and a dedicated "iszero" write port.
//
//   * Register 0 is hard-wired to zero; writes to it are dropped.
//   * Register ISZ_ADDR can only be written through the iszero port. Its
//     zero status is reported combinationally on iszero_flag.
//   * Register ACC_ADDR is mirrored combinationally on acc_data.
//   * Reads are synchronous and write-first. When a read and an accepted
//     write hit the same address at the same edge, the read returns the
//     new data.
//
// Parameters
//   DATA_W   register and data-port width
//   ADDR_W   address width, DEPTH = 2**ADDR_W registers
//   ACC_ADDR index mirrored on acc_data
//   ISZ_ADDR index owned by the iszero port
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous active-high reset
//   ra_a, ra_b    read addresses
//   rd_en         read enable, shared by both read ports
//   wa            general write address
//   write_data    general write data
//   reg_write     general write enable
//   iszero_data   iszero-port write data
//   iszero_write  iszero-port write enable
//   read_data_a   registered read result, port A
//   read_data_b   registered read result, port B
//   acc_data      contents of register ACC_ADDR
//   iszero_flag   high when register ISZ_ADDR is zero
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ACC_ADDR = 1,
    parameter int ISZ_ADDR = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra_a,
    input  logic [ADDR_W-1:0] ra_b,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] iszero_data,
    input  logic              iszero_write,
    output logic [DATA_W-1:0] read_data_a,
    output logic [DATA_W-1:0] read_data_b,
    output logic [DATA_W-1:0] acc_data,
    output logic              iszero_flag
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Refuse to build a file whose special registers collide with each
    // other, with the zero register, or fall outside the array.
    if (ACC_ADDR <= 0 || ACC_ADDR >= DEPTH ||
        ISZ_ADDR <= 0 || ISZ_ADDR >= DEPTH ||
        ACC_ADDR == ISZ_ADDR) begin : g_bad_params
        $fatal(1, "reg_file_param: illegal ACC_ADDR=%0d / ISZ_ADDR=%0d for DEPTH=%0d",
               ACC_ADDR, ISZ_ADDR, DEPTH);
    end

    localparam logic [ADDR_W-1:0] ACC_IDX  = ADDR_W'(ACC_ADDR);
    localparam logic [ADDR_W-1:0] ISZ_IDX  = ADDR_W'(ISZ_ADDR);
    localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

    logic [DATA_W-1:0] regs [DEPTH];

    logic              gen_accept;
    logic [DATA_W-1:0] next_a;
    logic [DATA_W-1:0] next_b;

    // The general port never reaches register 0 or the iszero register.
    // Only accepted writes may update state or feed the read bypass.
    assign gen_accept = reg_write && (wa != ZERO_IDX) && (wa != ISZ_IDX);

    // Register array. Register 0 is cleared by reset and never written.
    // The general and iszero ports can never target the same register,
    // so both may fire on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (gen_accept) begin
                regs[wa] <= write_data;
            end
            if (iszero_write) begin
                regs[ISZ_IDX] <= iszero_data;
            end
        end
    end

    // Port A read value with write-first bypass. Address 0 is forced to
    // zero so it reads correctly even before the first reset.
    always_comb begin
        next_a = regs[ra_a];
        if (ra_a == ZERO_IDX) begin
            next_a = '0;
        end else if (gen_accept && (wa == ra_a)) begin
            next_a = write_data;
        end else if (iszero_write && (ra_a == ISZ_IDX)) begin
            next_a = iszero_data;
        end
    end

    // Port B read value, same rules as port A.
    always_comb begin
        next_b = regs[ra_b];
        if (ra_b == ZERO_IDX) begin
            next_b = '0;
        end else if (gen_accept && (wa == ra_b)) begin
            next_b = write_data;
        end else if (iszero_write && (ra_b == ISZ_IDX)) begin
            next_b = iszero_data;
        end
    end

    // Read registers. They hold their value while rd_en is low.
    // Reset has priority over any read.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_data_a <= '0;
            read_data_b <= '0;
        end else if (rd_en) begin
            read_data_a <= next_a;
            read_data_b <= next_b;
        end
    end

    // Status outputs are taken straight from the stored state.
    assign acc_data    = regs[ACC_IDX];
    assign iszero_flag = (regs[ISZ_IDX] == '0);

endmodule
